// File: rtl/pwrmgr_ast_rsp_if.sv
// pwrmgr_ast_rsp_if: AST request/response bundle between the pwrmgr slow FSM and the AST responder
//   master: pwrmgr side (drives enables/power/clamp requests, receives valid/pok responses)
//   slave : AST responder side
interface pwrmgr_ast_rsp_if;
   logic core_clk_en_i;
   logic io_clk_en_i;
   logic usb_clk_en_i;
   logic main_pd_ni;
   logic pwr_clamp_i;
   logic pwr_clamp_env_i;
   logic slow_clk_en_i;
   logic core_clk_val_o;
   logic io_clk_val_o;
   logic usb_clk_val_o;
   logic main_pok_o;
   logic slow_clk_val_o;
   logic [1:0] err_o;
   modport master (
      output core_clk_en_i, io_clk_en_i, usb_clk_en_i, main_pd_ni,
             pwr_clamp_i, pwr_clamp_env_i, slow_clk_en_i,
      input  core_clk_val_o, io_clk_val_o, usb_clk_val_o, main_pok_o,
             slow_clk_val_o, err_o
   );
   modport slave (
      input  core_clk_en_i, io_clk_en_i, usb_clk_en_i, main_pd_ni,
             pwr_clamp_i, pwr_clamp_env_i, slow_clk_en_i,
      output core_clk_val_o, io_clk_val_o, usb_clk_val_o, main_pok_o,
             slow_clk_val_o, err_o
   );
endinterface

// File: rtl/pwrmgr_ast_rsp.sv
// pwrmgr_ast_rsp: AST stand-in answering pwrmgr clock/power requests with settle delays and checking sequencing
//   clk_i  : slow always-on clock
//   rst_ni : asynchronous active-low reset
//   ast    : slave modport of pwrmgr_ast_rsp_if
//            requests  core/io/usb_clk_en_i, main_pd_ni, pwr_clamp_i, pwr_clamp_env_i, slow_clk_en_i (ignored)
//            responses core/io/usb_clk_val_o, main_pok_o, slow_clk_val_o, err_o[1:0] (sticky)
//   Define PWRMGR_AST_RSP_JITTER_EN to add 0..3 LFSR-driven extra cycles to every delay load.
module pwrmgr_ast_rsp #(
   parameter int unsigned ClkOnCycles  = 4,
   parameter int unsigned ClkOffCycles = 2,
   parameter int unsigned PokOnCycles  = 8,
   parameter int unsigned PokOffCycles = 3,
   parameter int unsigned CntW         = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   pwrmgr_ast_rsp_if.slave  ast
);
   localparam logic [CntW-1:0] ClkOnLd  = CntW'(ClkOnCycles - 1);
   localparam logic [CntW-1:0] ClkOffLd = CntW'(ClkOffCycles - 1);
   localparam logic [CntW-1:0] PokOnLd  = CntW'(PokOnCycles - 1);
   localparam logic [CntW-1:0] PokOffLd = CntW'(PokOffCycles - 1);
   localparam logic [CntW-1:0] One      = CntW'(1);
   typedef enum logic [1:0] {ClkOff, ClkStarting, ClkOn, ClkStopping} clk_st_e;
   typedef enum logic [1:0] {PwrOn, PwrFalling, PwrOff, PwrRising} pwr_st_e;
   logic [CntW-1:0] w_jit;
`ifdef PWRMGR_AST_RSP_JITTER_EN
   logic [7:0] r_lfsr;
   // Fibonacci LFSR for x^8+x^6+x^5+x^4+1
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_lfsr <= 8'hA5;
      else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_jit = CntW'(r_lfsr[1:0]);
`else
   assign w_jit = '0;
`endif
   logic [2:0] w_en;
   logic [2:0] w_val;
   assign w_en = {ast.usb_clk_en_i, ast.io_clk_en_i, ast.core_clk_en_i};
   for (genvar g = 0; g < 3; g++) begin : g_ch
      clk_st_e         r_st;
      logic [CntW-1:0] r_cnt;
      // an enable change aborts a pending transition before the counter expiry is considered
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_st  <= ClkOff;
            r_cnt <= '0;
         end else begin
            case (r_st)
               ClkOff:
                  if (w_en[g]) begin
                     r_st  <= ClkStarting;
                     r_cnt <= ClkOnLd + w_jit;
                  end
               ClkStarting:
                  if (!w_en[g])           r_st  <= ClkOff;
                  else if (r_cnt == '0)   r_st  <= ClkOn;
                  else                    r_cnt <= r_cnt - One;
               ClkOn:
                  if (!w_en[g]) begin
                     r_st  <= ClkStopping;
                     r_cnt <= ClkOffLd + w_jit;
                  end
               ClkStopping:
                  if (w_en[g])            r_st  <= ClkOn;
                  else if (r_cnt == '0)   r_st  <= ClkOff;
                  else                    r_cnt <= r_cnt - One;
               default:                   r_st  <= ClkOff;
            endcase
         end
      end
      assign w_val[g] = (r_st == ClkOn) || (r_st == ClkStopping);
   end
   pwr_st_e         r_pwr_st;
   logic [CntW-1:0] r_pwr_cnt;
   logic            w_pok;
   logic            w_pwr_off_evt;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pwr_st  <= PwrOn;
         r_pwr_cnt <= '0;
      end else begin
         case (r_pwr_st)
            PwrOn:
               if (!ast.main_pd_ni) begin
                  r_pwr_st  <= PwrFalling;
                  r_pwr_cnt <= PokOffLd + w_jit;
               end
            PwrFalling:
               if (ast.main_pd_ni)         r_pwr_st  <= PwrOn;
               else if (r_pwr_cnt == '0)   r_pwr_st  <= PwrOff;
               else                        r_pwr_cnt <= r_pwr_cnt - One;
            PwrOff:
               if (ast.main_pd_ni) begin
                  r_pwr_st  <= PwrRising;
                  r_pwr_cnt <= PokOnLd + w_jit;
               end
            PwrRising:
               if (!ast.main_pd_ni)        r_pwr_st  <= PwrOff;
               else if (r_pwr_cnt == '0)   r_pwr_st  <= PwrOn;
               else                        r_pwr_cnt <= r_pwr_cnt - One;
            default:                       r_pwr_st  <= PwrOn;
         endcase
      end
   end
   assign w_pok         = (r_pwr_st == PwrOn) || (r_pwr_st == PwrFalling);
   assign w_pwr_off_evt = (r_pwr_st == PwrFalling) && !ast.main_pd_ni && (r_pwr_cnt == '0);
   logic       r_clamp_q;
   logic       r_slow_val;
   logic [1:0] r_err;
   // clamp ordering: clamp must be up when power drops, stay up while pok is low,
   // and only rise once the environment clamp is already up
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_clamp_q  <= 1'b0;
         r_slow_val <= 1'b0;
         r_err      <= 2'b00;
      end else begin
         r_clamp_q  <= ast.pwr_clamp_i;
         r_slow_val <= 1'b1;
         r_err[0]   <= r_err[0]
                     | (w_pwr_off_evt && !ast.pwr_clamp_i)
                     | (r_clamp_q && !ast.pwr_clamp_i && !w_pok)
                     | (!r_clamp_q && ast.pwr_clamp_i && !ast.pwr_clamp_env_i);
         r_err[1]   <= r_err[1] | (!w_pok && (ast.core_clk_en_i || ast.io_clk_en_i));
      end
   end
   logic w_unused;
   assign w_unused           = ast.slow_clk_en_i;
   assign ast.core_clk_val_o = w_val[0];
   assign ast.io_clk_val_o   = w_val[1];
   assign ast.usb_clk_val_o  = w_val[2];
   assign ast.main_pok_o     = w_pok;
   assign ast.slow_clk_val_o = r_slow_val;
   assign ast.err_o          = r_err;
endmodule

// File: doc/pwrmgr_ast_rsp.md
# pwrmgr_ast_rsp

Synthesizable responder for the power manager's AST request interface: consumes the clock-enable, main-power and clamp requests the slow power FSM drives toward AST and returns clock-valid and main-power-good responses with programmable settle delays. Used in Verilator and FPGA top levels that lack real analog AST. It also serves as a protocol checker: it flags out-of-order power-down sequencing. Runs on the always-on slow clock, in the same domain as the slow FSM.

## Interface
- ClkOnCycles, 4: `clk_en` high to `clk_val` high delay, in cycles (≥1).
- ClkOffCycles, 2: `clk_en` low to `clk_val` low delay, in cycles (≥1).
- PokOnCycles, 8: `main_pd_n` high to `main_pok` high delay, in cycles (≥1).
- PokOffCycles, 3: `main_pd_n` low to `main_pok` low delay, in cycles (≥1).
- CntW, 8: counter width; must satisfy 2^CntW > max(delay)+3.
- clk_i  in  1  slow always-on clock.
- rst_ni  in  1  reset: rst_ni, asynchronous, active-low; clock clk_i.
- core_clk_en_i / io_clk_en_i / usb_clk_en_i  in  1 each  clock source enable requests.
- main_pd_ni  in  1  main domain power request (1 = powered).
- pwr_clamp_i, pwr_clamp_env_i  in  1 each  isolation clamp requests.
- slow_clk_en_i  in  1  slow clock enable request (ignored; always 1 upstream).
- core_clk_val_o / io_clk_val_o / usb_clk_val_o  out  1 each  clock valid responses.
- main_pok_o  out  1  main power good.
- slow_clk_val_o  out  1  slow clock valid.
- err_o  out  2  sticky protocol errors: [0] clamp violation, [1] clock enabled while main off.

## Operation
- Three identical clock channels, each with a 4-state FSM: Off (val=0), Starting (val=0), On (val=1), Stopping (val=1). Each channel has its own CntW counter.
  - Off & en=1: load ClkOnCycles-1 and go to Starting.
  - Starting: decrement each cycle; at 0 go to On. If en=0, go to Off immediately.
  - On & en=0: load ClkOffCycles-1 and go to Stopping.
  - Stopping: decrement each cycle; at 0 go to Off. If en=1, go to On immediately.
  - val_o is a decode of the registered state, so it is glitch-free.
- Main power FSM: PwrOn (pok=1), PwrFalling (pok=1), PwrOff (pok=0), PwrRising (pok=0). Same load/decrement/abort rules as the clock channels, with pd_n as the enable and PokOn/PokOffCycles as the delays.
- err_o[0] sets on either event:
  - PwrFalling→PwrOff while pwr_clamp_i=0.
  - pwr_clamp_i falling while main_pok_o=0.
- err_o[1] sets on any cycle where main_pok_o=0 and (core_clk_en_i | io_clk_en_i) is high.
- err bits are sticky; only reset clears them.
- pwr_clamp_env_i is checked only for ordering: err_o[0] also sets if pwr_clamp_i rises while pwr_clamp_env_i=0.

## Timing
- Reset values:
  - All clock channels Off: all clk_val_o=0.
  - Main FSM PwrOn: main_pok_o=1. Upstream resets with the main domain assumed powered.
  - slow_clk_val_o=0; err_o=0.
- slow_clk_val_o goes to 1 at the first clk_i edge after reset release and stays 1.
- Latency:
  - Enable sampled high at edge t → val_o high after edge t+N, with N=ClkOnCycles (likewise for off and pok delays).
  - N=1 gives one-cycle latency.
- Simultaneous events:
  - Channels are independent.
  - An abort takes priority over counter expiry in the same cycle.
- Reset mid-count: the counter is discarded and state returns to the reset values.

## Configuration
- PWRMGR_AST_RSP_JITTER_EN defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every cycle.
  - Each counter load adds lfsr[1:0] (0..3) extra cycles to the programmed delay.
- Undefined: no LFSR; all delays are exactly as parameterized; deterministic.

## Test plan
- Reset, default params, no jitter → main_pok_o=1, all clk_val_o=0, err_o=0; slow_clk_val_o=1 one edge after release.
- core_clk_en_i rises at edge t → core_clk_val_o rises after edge t+4; en falls at edge u → val falls after edge u+2.
- io_clk_en_i pulses high for 2 cycles then low → io_clk_val_o stays 0 throughout.
- Correct power-down: clocks off, then pwr_clamp_env_i=1, pwr_clamp_i=1, main_pd_ni=0 at edge t → main_pok_o=0 after edge t+3; err_o=0. Then main_pd_ni=1 at edge v → main_pok_o=1 after edge v+8.
- main_pd_ni=0 with pwr_clamp_i=0 → err_o[0]=1 when pok falls, held until reset. core_clk_en_i=1 while pok=0 → err_o[1]=1.
- With PWRMGR_AST_RSP_JITTER_EN → every observed ClkOn latency lies in 4..7 cycles over 1000 toggles.
